// File: rtl/parity_engine_if.sv
// rtl/parity_engine_if.sv - control/status bundle between UART shift logic and the parity engine
interface parity_engine_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic             clr_cnt;
    logic             check_en;
    logic [2:0]       parity_type;

    logic             busy;
    logic             parity_out;
    logic             par_valid;
    logic             err;
    logic             frame_done;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output start, bit_valid, bit_in, clr_cnt, check_en, parity_type,
        input  busy, parity_out, par_valid, err, frame_done, err_cnt
    );

    modport slave (
        input  start, bit_valid, bit_in, clr_cnt, check_en, parity_type,
        output busy, parity_out, par_valid, err, frame_done, err_cnt
    );
endinterface

// File: rtl/parity_engine.sv
// rtl/parity_engine.sv - serial parity generator/checker with saturating error counter
module parity_engine #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    parity_engine_if.slave bus
);
    localparam int CNT_BITS = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                acc_q, acc_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]          type_q, type_d;
    logic                chk_q, chk_d;
    logic                busy_q, busy_d;
    logic                parity_out_q, parity_out_d;
    logic                par_valid_q, par_valid_d;
    logic                err_q, err_d;
    logic                frame_done_q, frame_done_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                err_inc;
    logic                acc_next;
    logic                is_none;
    logic                last_bit;

    // Unlisted encodings fall through to mark.
    function automatic logic parity_bit(input logic [2:0] t, input logic x);
        case (t)
            3'b001:         return ~x;
            3'b010:         return x;
            3'b100, 3'b101: return 1'b0;
            default:        return 1'b1;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        type_d       = type_q;
        chk_d        = chk_q;
        parity_out_d = parity_out_q;
        par_valid_d  = 1'b0;
        err_d        = 1'b0;
        frame_done_d = 1'b0;
        err_inc      = 1'b0;
        acc_next     = acc_q ^ bus.bit_in;
        is_none      = (type_q == 3'b101);
        last_bit     = (cnt_q == CNT_BITS'(DATA_BITS - 1));

        if (bus.start) begin
            // A start in any state (re)opens a frame; an aborted frame emits nothing.
            state_d = DATA;
            acc_d   = 1'b0;
            cnt_d   = '0;
            type_d  = bus.parity_type;
            chk_d   = bus.check_en;
        end else begin
            case (state_q)
                DATA: begin
                    if (bus.bit_valid) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CNT_BITS'(1);
                        if (last_bit) begin
                            parity_out_d = parity_bit(type_q, acc_next);
                            if (is_none) begin
                                state_d      = IDLE;
                                frame_done_d = 1'b1;
                            end else if (chk_q) begin
                                state_d     = PARITY;
                                par_valid_d = 1'b1;
                            end else begin
                                state_d      = IDLE;
                                par_valid_d  = 1'b1;
                                frame_done_d = 1'b1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bus.bit_valid) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        if (bus.bit_in != parity_out_q) begin
                            err_d   = 1'b1;
                            err_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);

        // Clear takes precedence over a same-cycle error increment.
        err_cnt_d = err_cnt_q;
        if (bus.clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            type_q       <= 3'b000;
            chk_q        <= 1'b0;
            busy_q       <= 1'b0;
            parity_out_q <= 1'b0;
            par_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            type_q       <= type_d;
            chk_q        <= chk_d;
            busy_q       <= busy_d;
            parity_out_q <= parity_out_d;
            par_valid_q  <= par_valid_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.parity_out = parity_out_q;
    assign bus.par_valid  = par_valid_q;
    assign bus.err        = err_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_parity_engine.sv
// tb/tb_parity_engine.sv - directed self-checking bench for parity_engine
module tb_parity_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a, start_b, bit_valid, bit_in, clr_cnt, check_en;
    logic [2:0] parity_type;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int fd_mark;

    always #5 clk = ~clk;

    parity_engine_if #(.CNT_W(2)) ifa ();
    parity_engine_if #(.CNT_W(8)) ifb ();

    assign ifa.start       = start_a;
    assign ifa.bit_valid   = bit_valid;
    assign ifa.bit_in      = bit_in;
    assign ifa.clr_cnt     = clr_cnt;
    assign ifa.check_en    = check_en;
    assign ifa.parity_type = parity_type;
    assign ifb.start       = start_b;
    assign ifb.bit_valid   = bit_valid;
    assign ifb.bit_in      = bit_in;
    assign ifb.clr_cnt     = clr_cnt;
    assign ifb.check_en    = check_en;
    assign ifb.parity_type = parity_type;

    parity_engine #(.DATA_BITS(8), .CNT_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    parity_engine #(.DATA_BITS(5), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always @(negedge clk) if (ifa.frame_done) fd_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start cycle carries a stray bit_valid, and mode inputs change right after.
    task automatic start_frame(input int sel, input logic [2:0] t, input logic c);
        parity_type = t;
        check_en    = c;
        bit_valid   = 1'b1;
        bit_in      = 1'b1;
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        tick();
        start_a     = 1'b0;
        start_b     = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        parity_type = t ^ 3'b011;
        check_en    = ~c;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_data(input logic [8:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(d[i]);
            if (i == 2) tick();
        end
    endtask

    task automatic gen_a(input string tag, input logic [2:0] t, input logic [8:0] d, input logic exp_p);
        start_frame(0, t, 1'b0);
        send_data(d, 8);
        check_eq({tag, "_parity"}, ifa.parity_out, exp_p);
        check_eq({tag, "_pv"}, ifa.par_valid, 1'b1);
    endtask

    task automatic chk_a(input string tag, input logic [8:0] d, input logic p,
                         input logic exp_err, input logic [1:0] exp_cnt);
        start_frame(0, 3'b010, 1'b1);
        send_data(d, 8);
        check_eq({tag, "_pv"}, ifa.par_valid, 1'b1);
        check_eq({tag, "_busy_par"}, ifa.busy, 1'b1);
        send_bit(p);
        check_eq({tag, "_err"}, ifa.err, exp_err);
        check_eq({tag, "_fd"}, ifa.frame_done, 1'b1);
        check_eq({tag, "_cnt"}, ifa.err_cnt, exp_cnt);
    endtask

    initial begin
        start_a = 0; start_b = 0; bit_valid = 0; bit_in = 0; clr_cnt = 0;
        check_en = 0; parity_type = 3'b000;
        tick(); tick();
        check_eq("rst_busy", ifa.busy, 1'b0);
        check_eq("rst_parity", ifa.parity_out, 1'b0);
        check_eq("rst_pv", ifa.par_valid, 1'b0);
        check_eq("rst_err", ifa.err, 1'b0);
        check_eq("rst_fd", ifa.frame_done, 1'b0);
        check_eq("rst_cnt", ifa.err_cnt, 2'd0);
        rst_n = 1'b1;
        tick();

        start_frame(0, 3'b010, 1'b0);
        check_eq("even_busy", ifa.busy, 1'b1);
        send_data(9'h0A5, 8);
        check_eq("even_a5_parity", ifa.parity_out, 1'b0);
        check_eq("even_a5_pv", ifa.par_valid, 1'b1);
        check_eq("even_a5_fd", ifa.frame_done, 1'b1);
        check_eq("even_a5_busy", ifa.busy, 1'b0);
        tick();
        check_eq("even_a5_pv_end", ifa.par_valid, 1'b0);
        check_eq("even_a5_fd_end", ifa.frame_done, 1'b0);

        gen_a("odd_a5", 3'b001, 9'h0A5, 1'b1);
        gen_a("odd_01", 3'b001, 9'h001, 1'b0);
        gen_a("mark7_00", 3'b111, 9'h000, 1'b1);
        gen_a("mark0_5a", 3'b000, 9'h05A, 1'b1);
        gen_a("space_ff", 3'b100, 9'h0FF, 1'b0);

        chk_a("chk_ok", 9'h007, 1'b1, 1'b0, 2'd0);
        chk_a("chk_bad", 9'h007, 1'b0, 1'b1, 2'd1);

        start_frame(0, 3'b101, 1'b1);
        send_data(9'h0A5, 8);
        check_eq("none_pv", ifa.par_valid, 1'b0);
        check_eq("none_fd", ifa.frame_done, 1'b1);
        check_eq("none_busy", ifa.busy, 1'b0);
        check_eq("none_parity", ifa.parity_out, 1'b0);
        send_bit(1'b1);
        check_eq("idle_bit_fd", ifa.frame_done, 1'b0);
        check_eq("idle_bit_err", ifa.err, 1'b0);
        check_eq("idle_bit_busy", ifa.busy, 1'b0);

        fd_mark = fd_cnt;
        start_frame(0, 3'b001, 1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        start_frame(0, 3'b010, 1'b0);
        check_eq("abort_fd", ifa.frame_done, 1'b0);
        send_data(9'h0FF, 8);
        check_eq("restart_parity", ifa.parity_out, 1'b0);
        check_eq("restart_fd", ifa.frame_done, 1'b1);
        tick();
        check_eq("restart_fd_count", fd_cnt - fd_mark, 1);

        start_frame(0, 3'b010, 1'b1);
        send_data(9'h007, 8);
        check_eq("pre_rst_pv", ifa.par_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", ifa.busy, 1'b0);
        check_eq("midrst_parity", ifa.parity_out, 1'b0);
        check_eq("midrst_pv", ifa.par_valid, 1'b0);
        check_eq("midrst_cnt", ifa.err_cnt, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_bit(1'b0);
        check_eq("postrst_err", ifa.err, 1'b0);
        check_eq("postrst_fd", ifa.frame_done, 1'b0);

        chk_a("sat1", 9'h007, 1'b0, 1'b1, 2'd1);
        chk_a("sat2", 9'h007, 1'b0, 1'b1, 2'd2);
        chk_a("sat3", 9'h007, 1'b0, 1'b1, 2'd3);
        chk_a("sat4", 9'h007, 1'b0, 1'b1, 2'd3);

        start_frame(0, 3'b010, 1'b1);
        send_data(9'h007, 8);
        clr_cnt = 1'b1;
        send_bit(1'b0);
        clr_cnt = 1'b0;
        check_eq("clr_err", ifa.err, 1'b1);
        check_eq("clr_cnt", ifa.err_cnt, 2'd0);
        chk_a("after_clr", 9'h007, 1'b0, 1'b1, 2'd1);

        start_frame(1, 3'b001, 1'b0);
        send_data(9'h01F, 5);
        check_eq("db5_1f_parity", ifb.parity_out, 1'b0);
        check_eq("db5_1f_pv", ifb.par_valid, 1'b1);
        check_eq("db5_1f_fd", ifb.frame_done, 1'b1);
        check_eq("db5_1f_busy", ifb.busy, 1'b0);
        check_eq("db5_a_idle", ifa.busy, 1'b0);
        start_frame(1, 3'b001, 1'b0);
        send_data(9'h003, 5);
        check_eq("db5_03_parity", ifb.parity_out, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
